fetch_stage: RTL and testbench

- Instruction-fetch block for the single-cycle datapath.
- Holds the program counter (PC) and advances it by 4 every clock.
- Reads the 32-bit instruction at the current PC from an internal byte-addressed instruction memory.
- A synchronous word-write port lets the bench or a loader fill the instruction memory.

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its driver: stall and loader write port in,
// program counter and fetched instruction out.
interface fetch_stage_if #(
    parameter int ADDR_W = 9
) ();
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [31:0]       instr;

    modport master (
        output stall, wr_en, wr_addr, wr_data,
        input  pc, pc_plus4, instr
    );

    modport slave (
        input  stall, wr_en, wr_addr, wr_data,
        output pc, pc_plus4, instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register with stall, PC adder, and a byte-addressed
// big-endian instruction memory with async read and a synchronous word-write port.
module fetch_stage #(
    parameter int          MEM_BYTES = 512,
    parameter int          ADDR_W    = 9,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PC_STEP   = 4
) (
    input logic          clk,
    input logic          rst_n,
    fetch_stage_if.slave bus
);

    logic [31:0]       pcReg;
    logic [31:0]       pcNext;
    logic [ADDR_W-1:0] rdIdx;
    logic [ADDR_W-1:0] wrIdx;

    // Power-up value of zero; the array is deliberately not touched by rst_n.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

    assign pcNext = pcReg + 32'(PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg <= RESET_PC;
        end else if (!bus.stall) begin
            pcReg <= pcNext;
        end
    end

    // ADDR_W-bit index arithmetic wraps every byte lane modulo MEM_BYTES.
    assign wrIdx = bus.wr_addr;

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[wrIdx]                 <= bus.wr_data[31:24];
            mem[wrIdx + ADDR_W'(1)]    <= bus.wr_data[23:16];
            mem[wrIdx + ADDR_W'(2)]    <= bus.wr_data[15:8];
            mem[wrIdx + ADDR_W'(3)]    <= bus.wr_data[7:0];
        end
    end

    assign rdIdx = pcReg[ADDR_W-1:0];

    assign bus.pc       = pcReg;
    assign bus.pc_plus4 = pcNext;
    assign bus.instr    = {mem[rdIdx],
                           mem[rdIdx + ADDR_W'(1)],
                           mem[rdIdx + ADDR_W'(2)],
                           mem[rdIdx + ADDR_W'(3)]};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a main instance at RESET_PC 0 and a second one
// reset near the top of the address space to exercise carry drop and byte wrap.
module tb_fetch_stage;

    logic clk;
    logic rst_n;

    fetch_stage_if #(.ADDR_W(9)) busA ();
    fetch_stage_if #(.ADDR_W(9)) busB ();

    fetch_stage #(
        .MEM_BYTES(512), .ADDR_W(9), .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dutA (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busA.slave)
    );

    fetch_stage #(
        .MEM_BYTES(512), .ADDR_W(9), .RESET_PC(32'hFFFF_FFFE), .PC_STEP(4)
    ) dutB (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busB.slave)
    );

    assign busB.stall   = busA.stall;
    assign busB.wr_en   = busA.wr_en;
    assign busB.wr_addr = busA.wr_addr;
    assign busB.wr_data = busA.wr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] instr;
    } expect_t;

    expect_t sb[$];
    int vecs = 0;
    int errs = 0;

    task automatic expect_out(input string tag, input int dut,
                              input logic [31:0] pcExp, input logic [31:0] instrExp);
        expect_t e;
        e.tag     = tag;
        e.dut     = dut;
        e.pc      = pcExp;
        e.pcPlus4 = pcExp + 32'd4;
        e.instr   = instrExp;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        expect_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                chk({e.tag, ".pc"},       busA.pc,       e.pc);
                chk({e.tag, ".pc_plus4"}, busA.pc_plus4, e.pcPlus4);
                chk({e.tag, ".instr"},    busA.instr,    e.instr);
            end else begin
                chk({e.tag, ".pc"},       busB.pc,       e.pc);
                chk({e.tag, ".pc_plus4"}, busB.pc_plus4, e.pcPlus4);
                chk({e.tag, ".instr"},    busB.instr,    e.instr);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        busA.stall   = 1'b0;
        busA.wr_en   = 1'b0;
        busA.wr_addr = '0;
        busA.wr_data = '0;
        #1;
        expect_out("reset_t0", 0, 32'h0000_0000, 32'h0000_0000);
        drain();

        repeat (3) tick();
        expect_out("reset_held",  0, 32'h0000_0000, 32'h0000_0000);
        expect_out("resetB_held", 1, 32'hFFFF_FFFE, 32'h0000_0000);
        drain();

        // Load two words while reset is still asserted.
        busA.wr_en   = 1'b1;
        busA.wr_addr = 9'd0;
        busA.wr_data = 32'h2008_0005;
        tick();
        busA.wr_addr = 9'd4;
        busA.wr_data = 32'h0109_5020;
        tick();
        busA.wr_en   = 1'b0;
        expect_out("loaded_in_reset", 0, 32'h0000_0000, 32'h2008_0005);
        expect_out("B_wrap_read",     1, 32'hFFFF_FFFE, 32'h0000_2008);
        drain();

        #2 rst_n = 1'b1;
        #1;
        expect_out("pre_edge1", 0, 32'h0000_0000, 32'h2008_0005);
        drain();

        tick();
        expect_out("edge1",        0, 32'h0000_0004, 32'h0109_5020);
        expect_out("B_carry_wrap", 1, 32'h0000_0002, 32'h0005_0109);
        drain();

        tick();
        expect_out("edge2", 0, 32'h0000_0008, 32'h0000_0000);
        drain();

        busA.stall = 1'b1;
        tick();
        tick();
        expect_out("stall_hold", 0, 32'h0000_0008, 32'h0000_0000);
        drain();
        busA.stall = 1'b0;
        tick();
        expect_out("stall_release", 0, 32'h0000_000C, 32'h0000_0000);
        drain();

        tick();
        tick();
        expect_out("run_to_20", 0, 32'h0000_0014, 32'h0000_0000);
        drain();

        // Asynchronous reset between edges; memory must survive it.
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 0, 32'h0000_0000, 32'h2008_0005);
        drain();
        tick();
        expect_out("async_reset_hold", 0, 32'h0000_0000, 32'h2008_0005);
        drain();
        #2 rst_n = 1'b1;
        tick();
        expect_out("restart", 0, 32'h0000_0004, 32'h0109_5020);
        drain();

        // Overwrite the word currently being fetched while stalled.
        busA.stall   = 1'b1;
        busA.wr_en   = 1'b1;
        busA.wr_addr = 9'd4;
        busA.wr_data = 32'hDEAD_BEEF;
        #1;
        expect_out("wr_before_edge", 0, 32'h0000_0004, 32'h0109_5020);
        drain();
        tick();
        expect_out("wr_after_edge", 0, 32'h0000_0004, 32'hDEAD_BEEF);
        drain();

        busA.wr_addr = 9'd508;
        busA.wr_data = 32'hAABB_CCDD;
        tick();
        busA.wr_en = 1'b0;
        busA.stall = 1'b0;

        repeat (126) tick();
        expect_out("pc_508", 0, 32'h0000_01FC, 32'hAABB_CCDD);
        drain();
        tick();
        expect_out("alias_512", 0, 32'h0000_0200, 32'h2008_0005);
        drain();

        #2 rst_n = 1'b0;
        #1;
        expect_out("final_reset",  0, 32'h0000_0000, 32'h2008_0005);
        expect_out("B_unaligned",  1, 32'hFFFF_FFFE, 32'hCCDD_2008);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
